traffic_light_monitor: RTL and testbench

Passive checker on the four 3-bit light buses driven by the four-way traffic light controller. Decodes each cycle's light pattern into a phase, tracks dwell time and phase order, and flags illegal light codes, out-of-order phases and dwell-time violations. It sits beside the controller in the top-level and in the bench as the consuming end of the light interface; it never drives the lights.

---
 rtl/tlm_pkg.sv | 49 ++++
 rtl/tlm_phase_decode.sv | 58 +++++
 rtl/traffic_light_monitor.sv | 185 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tlm_pkg.sv
// tlm_pkg: shared types for the traffic light monitor.
//   - light code constants RED / YELLOW / GREEN (one-hot, 3 bits)
//   - phase_t: decoded intersection phase, INVALID = 4'hF
//   - mon_state_t: SYNC / TRACK monitor states
//   - next_phase(): legal successor of a phase in the rotation
// Optional feature macro used by the monitor: TLM_TIMING_CHECK_EN.
package tlm_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam int DWELL_W = 6;

  typedef enum logic [3:0] {
    PH_ALL_RED = 4'd0,
    PH_N_Y     = 4'd1,
    PH_N_G     = 4'd2,
    PH_E_Y     = 4'd3,
    PH_E_G     = 4'd4,
    PH_S_Y     = 4'd5,
    PH_S_G     = 4'd6,
    PH_W_Y     = 4'd7,
    PH_W_G     = 4'd8,
    PH_INVALID = 4'hF
  } phase_t;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_t;

  // All-red only ever leads into north yellow; W_G wraps back to N_Y.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_ALL_RED: next_phase = PH_N_Y;
      PH_N_Y:     next_phase = PH_N_G;
      PH_N_G:     next_phase = PH_E_Y;
      PH_E_Y:     next_phase = PH_E_G;
      PH_E_G:     next_phase = PH_S_Y;
      PH_S_Y:     next_phase = PH_S_G;
      PH_S_G:     next_phase = PH_W_Y;
      PH_W_Y:     next_phase = PH_W_G;
      PH_W_G:     next_phase = PH_N_Y;
      default:    next_phase = PH_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/tlm_phase_decode.sv
// tlm_phase_decode: combinational decode of the four light buses into a phase.
// Ports:
//   north_lights, east_lights, south_lights, west_lights : 3-bit light codes
//   phase : decoded phase_t; INVALID when any bus holds a non-code value
//           (including X/Z) or more than one direction is non-red.
module tlm_phase_decode
  import tlm_pkg::*;
(
  input  logic [2:0] north_lights,
  input  logic [2:0] east_lights,
  input  logic [2:0] south_lights,
  input  logic [2:0] west_lights,
  output phase_t     phase
);

  logic [3:0][2:0] bus;
  logic            codes_ok;
  logic [2:0]      active_cnt;
  logic [1:0]      active_dir;
  logic            active_green;

  // Index 0..3 = N, E, S, W, matching the phase numbering order.
  assign bus = {west_lights, south_lights, east_lights, north_lights};

  always_comb begin
    codes_ok     = 1'b1;
    active_cnt   = '0;
    active_dir   = '0;
    active_green = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // case matches literally, so X/Z on a bus falls to default
      case (bus[i])
        RED: ;
        YELLOW: begin
          active_cnt   = active_cnt + 3'd1;
          active_dir   = 2'(i);
          active_green = 1'b0;
        end
        GREEN: begin
          active_cnt   = active_cnt + 3'd1;
          active_dir   = 2'(i);
          active_green = 1'b1;
        end
        default: codes_ok = 1'b0;
      endcase
    end

    if (!codes_ok || active_cnt > 3'd1) begin
      phase = PH_INVALID;
    end else if (active_cnt == 3'd0) begin
      phase = PH_ALL_RED;
    end else begin
      // direction d yellow = 2d+1, green = 2d+2
      phase = phase_t'({1'b0, active_dir, 1'b0} + {3'b000, active_green} + 4'd1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the four traffic light buses.
// Decodes the registered light sample into a phase, tracks dwell and phase
// order, and flags illegal codes, out-of-order phases and dwell violations.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   *_lights            : 3-bit light codes (red 100, yellow 010, green 001)
//   phase, phase_valid  : decoded phase of the previous sample, valid in TRACK
//   dwell               : cycles current phase held, saturating at 63
//   seq_err, timing_err, illegal_err : single-cycle error pulses
//   err_sticky          : {illegal, timing, seq}, cleared only by rst
//   rotations           : completed W_G->N_Y rotations, wrapping
// Macro TLM_TIMING_CHECK_EN enables dwell-window (overrun/underrun) checks;
// without it timing_err and err_sticky[1] stay 0.
//
// state | meaning
// SYNC  | waiting for a legal phase; no checks
// TRACK | every phase change checked against the legal order
module traffic_light_monitor
  import tlm_pkg::*;
#(
  parameter int ALL_RED_CYC = 10,
  parameter int YELLOW_CYC  = 5,
  parameter int GREEN_CYC   = 30,
  parameter int TOL         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         north_lights,
  input  logic [2:0]         east_lights,
  input  logic [2:0]         south_lights,
  input  logic [2:0]         west_lights,
  output logic [3:0]         phase,
  output logic               phase_valid,
  output logic [DWELL_W-1:0] dwell,
  output logic               seq_err,
  output logic               timing_err,
  output logic               illegal_err,
  output logic [2:0]         err_sticky,
  output logic [7:0]         rotations
);

  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

  // Overrun detection needs max+1 to be reachable before dwell saturates.
  if (ALL_RED_CYC + TOL + 1 > 63 || YELLOW_CYC + TOL + 1 > 63 ||
      GREEN_CYC + TOL + 1 > 63) begin : g_window_check
    $error("dwell window does not fit the 6-bit dwell counter");
  end

  phase_t             decoded;
  phase_t             sample_q;
  phase_t             phase_q;
  mon_state_t         state_q, state_d;
  logic               valid_q, valid_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               seq_q, seq_d;
  logic               timing_q, timing_d;
  logic               illegal_q, illegal_d;
  logic [2:0]         sticky_q, sticky_d;
  logic [7:0]         rotations_q, rotations_d;
  logic               phase_change;

  tlm_phase_decode u_decode (
    .north_lights (north_lights),
    .east_lights  (east_lights),
    .south_lights (south_lights),
    .west_lights  (west_lights),
    .phase        (decoded)
  );

`ifdef TLM_TIMING_CHECK_EN
  // First phase after SYNC has a partial dwell, so it is never timed.
  logic first_q, first_d;

  function automatic int nominal_cyc(input phase_t p);
    if (p == PH_ALL_RED)
      return ALL_RED_CYC;
    else if (p[0])
      return YELLOW_CYC;
    else
      return GREEN_CYC;
  endfunction
`endif

  always_comb begin
    state_d      = state_q;
    seq_d        = 1'b0;
    timing_d     = 1'b0;
    illegal_d    = 1'b0;
    rotations_d  = rotations_q;
    phase_change = (sample_q != phase_q);
`ifdef TLM_TIMING_CHECK_EN
    first_d      = first_q;
`endif

    if (phase_change)
      dwell_d = DWELL_W'(1);
    else if (dwell_q == DWELL_MAX)
      dwell_d = dwell_q;
    else
      dwell_d = dwell_q + DWELL_W'(1);

    case (state_q)
      ST_SYNC: begin
        if (sample_q != PH_INVALID) begin
          state_d = ST_TRACK;
`ifdef TLM_TIMING_CHECK_EN
          first_d = 1'b1;
`endif
        end
      end
      ST_TRACK: begin
        if (sample_q == PH_INVALID) begin
          illegal_d = 1'b1;
          state_d   = ST_SYNC;
        end else if (phase_change) begin
          if (sample_q != next_phase(phase_q))
            seq_d = 1'b1;
          else if (phase_q == PH_W_G)
            rotations_d = rotations_q + 8'd1;
`ifdef TLM_TIMING_CHECK_EN
          // dwell_q is the final dwell of the phase being left
          if (!first_q && int'(dwell_q) < nominal_cyc(phase_q))
            timing_d = 1'b1;
          first_d = 1'b0;
`endif
        end else begin
`ifdef TLM_TIMING_CHECK_EN
          // equality gives one pulse per phase even though dwell keeps counting
          if (!first_q && int'(dwell_d) == nominal_cyc(phase_q) + TOL + 1)
            timing_d = 1'b1;
`endif
        end
      end
    endcase

    valid_d  = (state_d == ST_TRACK) && (sample_q != PH_INVALID);
    sticky_d = sticky_q | {illegal_d, timing_d, seq_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q    <= PH_INVALID;
      phase_q     <= PH_INVALID;
      state_q     <= ST_SYNC;
      valid_q     <= 1'b0;
      dwell_q     <= '0;
      seq_q       <= 1'b0;
      timing_q    <= 1'b0;
      illegal_q   <= 1'b0;
      sticky_q    <= '0;
      rotations_q <= '0;
    end else begin
      sample_q    <= decoded;
      phase_q     <= sample_q;
      state_q     <= state_d;
      valid_q     <= valid_d;
      dwell_q     <= dwell_d;
      seq_q       <= seq_d;
      timing_q    <= timing_d;
      illegal_q   <= illegal_d;
      sticky_q    <= sticky_d;
      rotations_q <= rotations_d;
    end
  end

`ifdef TLM_TIMING_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)
      first_q <= 1'b0;
    else
      first_q <= first_d;
  end
`endif

  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign dwell       = dwell_q;
  assign seq_err     = seq_q;
  assign timing_err  = timing_q;
  assign illegal_err = illegal_q;
  assign err_sticky  = sticky_q;
  assign rotations   = rotations_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: table of {phase to drive, hold cycles,
// expected outputs at the end of the hold}. Pulse checks use cumulative
// counts of pulse cycles seen on the opposite clock edge.
module tb_traffic_light_monitor;

`ifdef TLM_TIMING_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif
  localparam int ILL = 99;  // north yellow + east green together

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] north_lights, east_lights, south_lights, west_lights;
  logic [3:0] phase;
  logic       phase_valid;
  logic [5:0] dwell;
  logic       seq_err, timing_err, illegal_err;
  logic [2:0] err_sticky;
  logic [7:0] rotations;

  traffic_light_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .north_lights (north_lights),
    .east_lights  (east_lights),
    .south_lights (south_lights),
    .west_lights  (west_lights),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .dwell        (dwell),
    .seq_err      (seq_err),
    .timing_err   (timing_err),
    .illegal_err  (illegal_err),
    .err_sticky   (err_sticky),
    .rotations    (rotations)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    int         hold;
    int         e_phase;
    int         e_dwell;
    int         e_valid;
    int         e_seq;     // cumulative pulse-cycle counts
    int         e_tim;     // assuming timing checks enabled
    int         e_ill;
    int         e_rot;
    logic [2:0] e_sticky;  // assuming timing checks enabled
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int seq_cnt = 0, tim_cnt = 0, ill_cnt = 0, last_tim_dwell = 0;
  vec_t tab_a[$];
  vec_t tab_b[$];

  always @(negedge clk) begin
    if (seq_err)     seq_cnt++;
    if (illegal_err) ill_cnt++;
    if (timing_err) begin
      tim_cnt++;
      last_tim_dwell = int'(dwell);
    end
  end

  function automatic vec_t mk(int ph, int hold, int ep, int ed, int ev,
                              int es, int et, int ei, int er, logic [2:0] est);
    vec_t v;
    v.ph = ph; v.hold = hold; v.e_phase = ep; v.e_dwell = ed; v.e_valid = ev;
    v.e_seq = es; v.e_tim = et; v.e_ill = ei; v.e_rot = er; v.e_sticky = est;
    return v;
  endfunction

  // {north, east, south, west}
  function automatic logic [11:0] lights_for(int p);
    logic [2:0] l [4];
    for (int i = 0; i < 4; i++) l[i] = 3'b100;
    if (p == ILL) begin
      l[0] = 3'b010;
      l[1] = 3'b001;
    end else if (p >= 1 && p <= 8) begin
      l[(p - 1) / 2] = (p % 2 == 1) ? 3'b010 : 3'b001;
    end
    return {l[0], l[1], l[2], l[3]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    @(negedge clk);
    {north_lights, east_lights, south_lights, west_lights} = lights_for(v.ph);
    repeat (v.hold) @(posedge clk);
    #1;
    n_vec++;
    tag = $sformatf("v%0d", idx);
    chk({tag, " phase"},       int'(phase),       v.e_phase);
    chk({tag, " dwell"},       int'(dwell),       v.e_dwell);
    chk({tag, " phase_valid"}, int'(phase_valid), v.e_valid);
    chk({tag, " seq pulses"},  seq_cnt,           v.e_seq);
    chk({tag, " tim pulses"},  tim_cnt,           TCHK ? v.e_tim : 0);
    chk({tag, " ill pulses"},  ill_cnt,           v.e_ill);
    chk({tag, " rotations"},   int'(rotations),   v.e_rot);
    chk({tag, " err_sticky"},  int'(err_sticky),
        int'(TCHK ? v.e_sticky : (v.e_sticky & 3'b101)));
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    chk({tag, " phase"},       int'(phase),       15);
    chk({tag, " phase_valid"}, int'(phase_valid), 0);
    chk({tag, " dwell"},       int'(dwell),       0);
    chk({tag, " pulses"},      int'({seq_err, timing_err, illegal_err}), 0);
    chk({tag, " err_sticky"},  int'(err_sticky),  0);
    chk({tag, " rotations"},   int'(rotations),   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // clean rotation, then seq jump N_G->S_Y, underrun E_Y, overrun E_G,
    // illegal pattern, out-of-order resync, then tracked rotation up to W_G
    tab_a.push_back(mk(0, 10, 0,  9, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(1,  5, 1,  4, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(2, 30, 2, 29, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(3,  5, 3,  4, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(4, 30, 4, 29, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(5,  5, 5,  4, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(6, 30, 6, 29, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(7,  5, 7,  4, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(8, 30, 8, 29, 1, 0, 0, 0, 0, 3'b000));
    tab_a.push_back(mk(1,  5, 1,  4, 1, 0, 0, 0, 1, 3'b000));
    tab_a.push_back(mk(2, 30, 2, 29, 1, 0, 0, 0, 1, 3'b000));
    tab_a.push_back(mk(5,  5, 5,  4, 1, 1, 0, 0, 1, 3'b001));
    tab_a.push_back(mk(6, 30, 6, 29, 1, 1, 0, 0, 1, 3'b001));
    tab_a.push_back(mk(7,  5, 7,  4, 1, 1, 0, 0, 1, 3'b001));
    tab_a.push_back(mk(8, 30, 8, 29, 1, 1, 0, 0, 1, 3'b001));
    tab_a.push_back(mk(1,  5, 1,  4, 1, 1, 0, 0, 2, 3'b001));
    tab_a.push_back(mk(2, 30, 2, 29, 1, 1, 0, 0, 2, 3'b001));
    tab_a.push_back(mk(3,  3, 3,  2, 1, 1, 0, 0, 2, 3'b001));
    tab_a.push_back(mk(4, 33, 4, 32, 1, 1, 1, 0, 2, 3'b011));
    tab_a.push_back(mk(5,  5, 5,  4, 1, 1, 2, 0, 2, 3'b011));
    tab_a.push_back(mk(ILL, 3, 15, 2, 0, 1, 2, 1, 2, 3'b111));
    tab_a.push_back(mk(8, 10, 8,  9, 1, 1, 2, 1, 2, 3'b111));
    tab_a.push_back(mk(1,  5, 1,  4, 1, 1, 2, 1, 3, 3'b111));
    tab_a.push_back(mk(2, 30, 2, 29, 1, 1, 2, 1, 3, 3'b111));
    tab_a.push_back(mk(3,  5, 3,  4, 1, 1, 2, 1, 3, 3'b111));
    tab_a.push_back(mk(4, 30, 4, 29, 1, 1, 2, 1, 3, 3'b111));
    tab_a.push_back(mk(5,  5, 5,  4, 1, 1, 2, 1, 3, 3'b111));
    tab_a.push_back(mk(6, 30, 6, 29, 1, 1, 2, 1, 3, 3'b111));
    tab_a.push_back(mk(7,  5, 7,  4, 1, 1, 2, 1, 3, 3'b111));
    tab_a.push_back(mk(8, 12, 8, 11, 1, 1, 2, 1, 3, 3'b111));
    // after mid-W_G reset: overrun on a tracked N_G held long enough to saturate
    tab_b.push_back(mk(0, 10, 0,  9, 1, 1, 2, 1, 0, 3'b000));
    tab_b.push_back(mk(1,  5, 1,  4, 1, 1, 2, 1, 0, 3'b000));
    tab_b.push_back(mk(2, 70, 2, 63, 1, 1, 3, 1, 0, 3'b010));

    rst = 1'b1;
    {north_lights, east_lights, south_lights, west_lights} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tab_a.size(); i++) run_vec(i, tab_a[i]);

    n_vec++;
    chk("overrun dwell", last_tim_dwell, TCHK ? 33 : 0);

    // reset for one cycle in the middle of W_G; lights parked invalid so the
    // restart begins cleanly from SYNC
    @(negedge clk);
    rst = 1'b1;
    {north_lights, east_lights, south_lights, west_lights} = '0;
    @(posedge clk);
    #1;
    check_reset_values("mid reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tab_b.size(); i++) run_vec(100 + i, tab_b[i]);

    n_vec++;
    chk("saturated overrun dwell", last_tim_dwell, TCHK ? 33 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
